// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
// Imported by hazard_detect and pipeline_hazard_ctrl.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    HALT
  } pctrl_state_t;

  localparam int REGW_DEF        = 5;
  localparam int MEM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use detector: load in E whose dest feeds a source of D.
// Register x0 is hardwired zero, so it never creates a dependency.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REGW = REGW_DEF
) (
  input  logic [REGW-1:0] rs1_d,
  input  logic [REGW-1:0] rs2_d,
  input  logic [REGW-1:0] rd_e,
  input  logic            memread_e,
  output logic            load_use
);

  assign load_use = memread_e
                  && (rd_e != '0)
                  && ((rd_e == rs1_d) || (rd_e == rs2_d));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the F/D/E/M/W pipeline.
// Outputs are combinational; only state, wait counter and halted are flops.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REGW        = REGW_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] rs1_d,
  input  logic [REGW-1:0] rs2_d,
  input  logic [REGW-1:0] rd_e,
  input  logic            memread_e,
  input  logic            branch_taken_e,
  input  logic            mem_req_m,
  input  logic            mem_ready_m,
  input  logic            exc_m,
  output logic            stall_f,
  output logic            stall_d,
  output logic            stall_e,
  output logic            stall_m,
  output logic            flush_d,
  output logic            flush_e,
  output logic            flush_m,
  output logic            flush_w,
  output logic            trap_redirect,
  output logic            halted
);

  localparam int CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  pctrl_state_t  state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          halted_nxt;
  logic          load_use;
  logic          mem_wait;

  hazard_detect #(.REGW(REGW)) u_hd (
    .rs1_d     (rs1_d),
    .rs2_d     (rs2_d),
    .rd_e      (rd_e),
    .memread_e (memread_e),
    .load_use  (load_use)
  );

  assign mem_wait = mem_req_m && !mem_ready_m;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      cnt    <= '0;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      halted <= halted_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    halted_nxt    = halted;
    stall_f       = 1'b0;
    stall_d       = 1'b0;
    stall_e       = 1'b0;
    stall_m       = 1'b0;
    flush_d       = 1'b0;
    flush_e       = 1'b0;
    flush_m       = 1'b0;
    flush_w       = 1'b0;
    trap_redirect = 1'b0;
    if (reset) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_m = 1'b1;
      flush_w = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (mem_wait) begin
            {stall_f, stall_d, stall_e, stall_m} = 4'hf;
            flush_w   = 1'b1;
            state_nxt = MEM_WAIT;
            cnt_nxt   = CW'(1);
          end else if (exc_m) begin
            {flush_d, flush_e, flush_m} = 3'b111;
            trap_redirect = 1'b1;
          end else if (branch_taken_e) begin
            {flush_d, flush_e} = 2'b11;
          end else if (load_use) begin
            {stall_f, stall_d} = 2'b11;
            flush_e = 1'b1;
          end
        end
        MEM_WAIT: begin
          // The M access must finish before anything else is honoured.
          if (mem_ready_m) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            {stall_f, stall_d, stall_e, stall_m} = 4'hf;
            flush_w = 1'b1;
            if (cnt == CNT_LAST) begin
              state_nxt  = HALT;
              halted_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end
        end
        HALT: begin
          {stall_f, stall_d, stall_e, stall_m} = 4'hf;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4).
// Table vectors for RUN decode plus multi-cycle wait/timeout/reset sequences.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1_d, rs2_d, rd_e;
  logic       memread_e, branch_taken_e, mem_req_m, mem_ready_m, exc_m;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_m, flush_w;
  logic       trap_redirect, halted;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REGW(5), .MEM_TIMEOUT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .rs1_d          (rs1_d),
    .rs2_d          (rs2_d),
    .rd_e           (rd_e),
    .memread_e      (memread_e),
    .branch_taken_e (branch_taken_e),
    .mem_req_m      (mem_req_m),
    .mem_ready_m    (mem_ready_m),
    .exc_m          (exc_m),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .stall_e        (stall_e),
    .stall_m        (stall_m),
    .flush_d        (flush_d),
    .flush_e        (flush_e),
    .flush_m        (flush_m),
    .flush_w        (flush_w),
    .trap_redirect  (trap_redirect),
    .halted         (halted)
  );

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       mr, br, req, rdy, exc;
    logic [3:0] stl;
    logic [3:0] fl;
    logic       trap;
  } vec_t;

  vec_t vecs[10];

  task automatic setin(input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic mr,
                       input logic br, input logic req,
                       input logic rdy, input logic exc);
    rs1_d = r1; rs2_d = r2; rd_e = rd;
    memread_e = mr; branch_taken_e = br;
    mem_req_m = req; mem_ready_m = rdy; exc_m = exc;
  endtask

  // Expected {stall_f..m, flush_d..w, trap_redirect}
  task automatic chk(input string name, input logic [3:0] stl,
                     input logic [3:0] fl, input logic trap);
    logic [8:0] act, exp;
    #1;
    act = {stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_m, flush_w, trap_redirect};
    exp = {stl, fl, trap};
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk_h(input string name, input logic exp);
    n_run++;
    if (halted !== exp) begin
      n_fail++;
      $display("FAIL %s: halted got %b want %b", name, halted, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{"idle",      0, 0, 0, 0,0,0,0,0, 4'b0000, 4'b0000, 0};
    vecs[1] = '{"lu_rs1",    5, 9, 5, 1,0,0,0,0, 4'b1100, 4'b0100, 0};
    vecs[2] = '{"lu_rs2",    2, 7, 7, 1,0,0,0,0, 4'b1100, 4'b0100, 0};
    vecs[3] = '{"lu_x0",     0, 4, 0, 1,0,0,0,0, 4'b0000, 4'b0000, 0};
    vecs[4] = '{"lu_both",   3, 3, 3, 1,0,0,0,0, 4'b1100, 4'b0100, 0};
    vecs[5] = '{"no_load",   6, 6, 6, 0,0,0,0,0, 4'b0000, 4'b0000, 0};
    vecs[6] = '{"br_lu",     5, 1, 5, 1,1,0,0,0, 4'b0000, 4'b1100, 0};
    vecs[7] = '{"exc_br_lu", 5, 1, 5, 1,1,0,0,1, 4'b0000, 4'b1110, 1};
    vecs[8] = '{"mem_rdy",   0, 0, 0, 0,0,1,1,0, 4'b0000, 4'b0000, 0};
    vecs[9] = '{"mem_rdy_x", 0, 0, 0, 0,0,1,1,1, 4'b0000, 4'b1110, 1};

    reset = 1'b1;
    setin(5, 0, 5, 1, 0, 0, 0, 0);
    step;
    chk("reset_out", 4'b0000, 4'b1111, 0);
    chk_h("reset_halted", 0);

    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step;
      setin(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].mr,
            vecs[i].br, vecs[i].req, vecs[i].rdy, vecs[i].exc);
      chk(vecs[i].name, vecs[i].stl, vecs[i].fl, vecs[i].trap);
    end

    // Wait ending on the last allowed cycle: ready must beat timeout.
    step; setin(0, 0, 0, 0, 0, 1, 0, 0);
    chk("mw_c0", 4'b1111, 4'b0001, 0);
    step; chk("mw_c1", 4'b1111, 4'b0001, 0);
    step; chk("mw_c2", 4'b1111, 4'b0001, 0);
    step; mem_ready_m = 1'b1;
    chk("mw_ready", 4'b0000, 4'b0000, 0);
    step; setin(5, 0, 5, 1, 0, 0, 0, 0);
    chk("mw_back_run", 4'b1100, 4'b0100, 0);
    chk_h("mw_no_halt", 0);

    // Exception held through a wait is deferred to the next RUN cycle.
    step; setin(0, 0, 0, 0, 0, 1, 0, 1);
    chk("exw_c0", 4'b1111, 4'b0001, 0);
    step; chk("exw_c1", 4'b1111, 4'b0001, 0);
    step; mem_ready_m = 1'b1;
    chk("exw_ready", 4'b0000, 4'b0000, 0);
    step; setin(0, 0, 0, 0, 0, 0, 0, 1);
    chk("exw_trap", 4'b0000, 4'b1110, 1);
    step; exc_m = 1'b0;
    chk("exw_trap_gone", 4'b0000, 4'b0000, 0);

    // Reset while in MEM_WAIT.
    step; setin(0, 0, 0, 0, 0, 1, 0, 0);
    chk("rmw_c0", 4'b1111, 4'b0001, 0);
    step; chk("rmw_c1", 4'b1111, 4'b0001, 0);
    reset = 1'b1;
    chk("rmw_reset", 4'b0000, 4'b1111, 0);
    step; reset = 1'b0;
    mem_req_m = 1'b0;
    setin(0, 0, 0, 0, 1, 0, 0, 0);
    chk("rmw_run", 4'b0000, 4'b1100, 0);
    chk_h("rmw_halted", 0);

    // Timeout: ready never arrives.
    step; setin(0, 0, 0, 0, 0, 1, 0, 0);
    chk("to_c0", 4'b1111, 4'b0001, 0);
    step; chk("to_c1", 4'b1111, 4'b0001, 0);
    step; chk("to_c2", 4'b1111, 4'b0001, 0);
    step; chk("to_c3", 4'b1111, 4'b0001, 0);
    chk_h("to_c3_halted", 0);
    step; chk("to_halt", 4'b1111, 4'b0000, 0);
    chk_h("to_halted", 1);
    mem_ready_m = 1'b1;
    exc_m = 1'b1;
    chk("halt_rdy_exc", 4'b1111, 4'b0000, 0);
    step; chk("halt_sticky", 4'b1111, 4'b0000, 0);
    chk_h("halt_sticky_h", 1);

    reset = 1'b1;
    chk("halt_reset", 4'b0000, 4'b1111, 0);
    step; reset = 1'b0;
    setin(0, 0, 0, 0, 0, 0, 0, 0);
    chk("halt_exit", 4'b0000, 4'b0000, 0);
    chk_h("halt_cleared", 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
